flash_playback_sequencer: RTL
=============================

// Module: flash_playback_sequencer
// PURPOSE
//  Playback controller between the flash word reader and the audio codec write port.
//  - Schedules flash word fetches over [START_ADDR..END_ADDR].
//  - Forwards each 16-bit signed sample to both codec channels using the write_s/write_ready handshake.
//  - Adds play/pause/stop control, loop mode and 3 playback speeds; replaces the top-level ad-hoc FSM.
// PARAMETERS
//  ADDR_W      21         flash word-address width
//  START_ADDR  0          first word address of clip
//  END_ADDR    21'h1FFFFF last word address of clip (inclusive), must be >= START_ADDR
// PORTS
//  CLOCK_50        in   1       system clock; all logic on posedge
//  reset           in   1       synchronous, active-high reset
//  cmd_play        in   1       1-cycle pulse: start/resume playback
//  cmd_pause       in   1       1-cycle pulse: pause at next sample boundary
//  cmd_stop        in   1       1-cycle pulse: stop at next sample boundary
//  loop_en         in   1       1 = wrap to START_ADDR at clip end
//  speed           in   2       00 normal, 01 half (each sample written twice), 10 double (addr += 2), 11 = 00
//  fl_addr         out  ADDR_W  word address presented to flash reader
//  fl_req          out  1       fetch request; held high until fl_valid
//  fl_valid        in   1       1-cycle pulse: fl_data valid for fl_addr
//  fl_data         in   16      flash sample word
//  write_ready     in   1       codec can accept a sample
//  write_s         out  1       codec write strobe
//  writedata_left  out  16      left sample
//  writedata_right out  16      right sample (always == left)
//  busy            out  1       1 in FETCH..WAIT_ACCEPT
//  paused          out  1       1 in PAUSED
//  done            out  1       1 in DONE (non-loop clip end)
// BEHAVIOUR
//  - All outputs registered.
//  - Reset values: state=IDLE, fl_addr=START_ADDR, fl_req=0, write_s=0, writedata_*=0, busy=paused=done=0; pending flags cleared.
//  - Reset mid-operation aborts unconditionally. The flash reader is reset by the same reset.
//  - FSM states:
//    IDLE: cmd_play -> FETCH, fl_addr<=START_ADDR.
//    FETCH: fl_req<=1 -> WAIT_FLASH. fl_req goes high 2 cycles after the play pulse edge.
//    WAIT_FLASH: on fl_valid: sample<=fl_data, fl_req<=0, rep<=0 -> WAIT_READY. fl_valid outside WAIT_FLASH is ignored.
//    WAIT_READY: on write_ready: writedata_l/r<=sample, write_s<=1 -> WAIT_ACCEPT.
//    WAIT_ACCEPT: hold write_s=1 until write_ready==0, then write_s<=0.
//      If spd==01 and rep==0: rep<=1, re-enter WAIT_READY (same sample).
//      Otherwise go to BOUNDARY decision.
//    BOUNDARY (combinational decision, not a state), in priority order:
//      1. stop_pend -> IDLE.
//      2. pause_pend -> PAUSED.
//      3. nxt = fl_addr + step (ADDR_W+1 bits; step = 2 if spd==10, else 1).
//         If nxt > END_ADDR: loop_en ? (fl_addr<=START_ADDR, FETCH) : DONE.
//         Otherwise fl_addr<=nxt, FETCH.
//      When taken, clears both pending flags.
//    PAUSED: fl_addr already advanced. cmd_play -> FETCH (resume). cmd_stop -> IDLE.
//    DONE: cmd_play -> FETCH at START_ADDR. cmd_stop -> IDLE.
//  - Command handling:
//    cmd_pause / cmd_stop are set-only latches while busy.
//    Same cycle: stop beats pause beats play.
//    cmd_play while busy is ignored. cmd_pause/stop in IDLE are ignored.
//  - spd is captured from speed at IDLE/PAUSED/DONE->FETCH and at each BOUNDARY; it is constant within a sample.
//  - Clip-end boundaries:
//    START_ADDR==END_ADDR: one sample per pass.
//    Double speed with odd span: the last word is skipped, never read past END_ADDR.
//  - No sample is ever dropped or written twice except by the half-speed rule. The codec sees exactly one write_s rise per write.
// CONFIGURATION
//  - VOLUME_EN defined:
//    Adds input vol_shift[2:0].
//    writedata_l/r <= $signed(sample) >>> vol_shift (arithmetic shift, sign preserved), sampled in WAIT_READY.
//  - VOLUME_EN undefined: port absent; sample passed unmodified.
// TESTING
//  - Normal: START=0, END=3, speed=00, loop=0; flash returns addr+16'h100, write_ready toggles.
//    -> codec gets 0100,0101,0102,0103 on both channels, then done=1 and fl_req stays 0.
//  - Half speed: END=1, speed=01.
//    -> writes 0100,0100,0101,0101 (4 write_s pulses); done=1.
//  - Double + loop: END=4, speed=10, loop=1.
//    -> fetch addresses 0,2,4,0,2,...; done never asserts; cmd_stop -> IDLE after the in-flight write completes.
//  - Pause/resume: cmd_pause during WAIT_FLASH at addr 2.
//    -> sample 2 still written, paused=1, fl_addr=3. cmd_play -> next fetch at addr 3.
//  - Simultaneous: cmd_stop and cmd_pause in the same cycle while busy -> IDLE, paused never 1.
//    reset=1 mid-WAIT_ACCEPT -> write_s=0 and state IDLE next cycle.
//  - VOLUME_EN: vol_shift=2, sample 16'h8000 -> writedata 16'hE000; 16'h0100 -> 16'h0040.

Source files
------------

// File: rtl/flash_playback_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : flash_playback_sequencer
//  Description : Playback controller between the flash word reader and the
//                audio codec write port. Fetches clip words over
//                [START_ADDR..END_ADDR] and forwards each signed sample to
//                both codec channels. It supports play/pause/stop, loop mode
//                and normal/half/double speed.
//                Optional feature macro: VOLUME_EN (adds vol_shift input,
//                arithmetic right shift of each sample).
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_playback_sequencer #(
  parameter int                 ADDR_W     = 21,
  parameter logic [ADDR_W-1:0]  START_ADDR = '0,
  parameter logic [ADDR_W-1:0]  END_ADDR   = 21'h1FFFFF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cmd_play,
  input  logic              cmd_pause,
  input  logic              cmd_stop,
  input  logic              loop_en,
  input  logic [1:0]        speed,
  output logic [ADDR_W-1:0] fl_addr,
  output logic              fl_req,
  input  logic              fl_valid,
  input  logic [15:0]       fl_data,
  input  logic              write_ready,
  output logic              write_s,
  output logic [15:0]       writedata_left,
  output logic [15:0]       writedata_right,
  output logic              busy,
  output logic              paused,
  output logic              done
`ifdef VOLUME_EN
  ,
  input  logic [2:0]        vol_shift
`endif
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_FETCH       = 3'd1,
    S_WAIT_FLASH  = 3'd2,
    S_WAIT_READY  = 3'd3,
    S_WAIT_ACCEPT = 3'd4,
    S_PAUSED      = 3'd5,
    S_DONE        = 3'd6
  } state_t;

  localparam logic [1:0] c_SPD_NORMAL = 2'b00;
  localparam logic [1:0] c_SPD_HALF   = 2'b01;
  localparam logic [1:0] c_SPD_DOUBLE = 2'b10;

  state_t            r_state;
  logic [1:0]        r_spd;
  logic              r_rep;
  logic              r_stop_pend;
  logic              r_pause_pend;
  logic [15:0]       r_sample;

  logic              w_in_flight;
  logic              w_stop;
  logic              w_pause;
  logic [1:0]        w_spd_in;
  logic [ADDR_W:0]   w_step;
  logic [ADDR_W:0]   w_nxt;
  logic              w_clip_end;
  logic [ADDR_W-1:0] w_adv_addr;
  logic [15:0]       w_out;

  // a sample is in flight from FETCH through WAIT_ACCEPT
  assign w_in_flight = (r_state == S_FETCH)      || (r_state == S_WAIT_FLASH) ||
                       (r_state == S_WAIT_READY) || (r_state == S_WAIT_ACCEPT);

  // commands arriving in the boundary cycle itself still count
  assign w_stop  = r_stop_pend  | cmd_stop;
  assign w_pause = r_pause_pend | cmd_pause;

  // speed code 11 behaves as normal speed
  assign w_spd_in = (speed == 2'b11) ? c_SPD_NORMAL : speed;

  // one extra bit so the comparison cannot wrap at the top of the address space
  assign w_step     = (r_spd == c_SPD_DOUBLE) ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
  assign w_nxt      = {1'b0, fl_addr} + w_step;
  assign w_clip_end = (w_nxt > {1'b0, END_ADDR});
  assign w_adv_addr = w_clip_end ? START_ADDR : w_nxt[ADDR_W-1:0];

`ifdef VOLUME_EN
  assign w_out = 16'($signed(r_sample) >>> vol_shift);
`else
  assign w_out = r_sample;
`endif

  // playback FSM with all outputs registered alongside the state
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_spd           <= c_SPD_NORMAL;
      r_rep           <= 1'b0;
      r_stop_pend     <= 1'b0;
      r_pause_pend    <= 1'b0;
      r_sample        <= '0;
      fl_addr         <= START_ADDR;
      fl_req          <= 1'b0;
      write_s         <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
      busy            <= 1'b0;
      paused          <= 1'b0;
      done            <= 1'b0;
    end else begin
      // pause/stop are remembered until the next sample boundary
      if (w_in_flight) begin
        if (cmd_stop)  r_stop_pend  <= 1'b1;
        if (cmd_pause) r_pause_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_play) begin
            r_state <= S_FETCH;
            fl_addr <= START_ADDR;
            r_spd   <= w_spd_in;
            busy    <= 1'b1;
          end
        end

        S_FETCH: begin
          fl_req  <= 1'b1;
          r_state <= S_WAIT_FLASH;
        end

        S_WAIT_FLASH: begin
          if (fl_valid) begin
            r_sample <= fl_data;
            fl_req   <= 1'b0;
            r_rep    <= 1'b0;
            r_state  <= S_WAIT_READY;
          end
        end

        S_WAIT_READY: begin
          if (write_ready) begin
            writedata_left  <= w_out;
            writedata_right <= w_out;
            write_s         <= 1'b1;
            r_state         <= S_WAIT_ACCEPT;
          end
        end

        S_WAIT_ACCEPT: begin
          if (!write_ready) begin
            write_s <= 1'b0;
            if ((r_spd == c_SPD_HALF) && !r_rep) begin
              // half speed: present the same sample a second time
              r_rep   <= 1'b1;
              r_state <= S_WAIT_READY;
            end else begin
              // sample boundary: stop, then pause, then advance
              r_stop_pend  <= 1'b0;
              r_pause_pend <= 1'b0;
              r_spd        <= w_spd_in;
              if (w_stop) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end else if (w_pause) begin
                // address advances (or wraps) so resume fetches the next word
                r_state <= S_PAUSED;
                fl_addr <= w_adv_addr;
                busy    <= 1'b0;
                paused  <= 1'b1;
              end else if (w_clip_end && !loop_en) begin
                r_state <= S_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                r_state <= S_FETCH;
                fl_addr <= w_adv_addr;
              end
            end
          end
        end

        S_PAUSED: begin
          if (cmd_stop) begin
            r_state <= S_IDLE;
            paused  <= 1'b0;
          end else if (cmd_play) begin
            r_state <= S_FETCH;
            r_spd   <= w_spd_in;
            paused  <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_DONE: begin
          if (cmd_stop) begin
            r_state <= S_IDLE;
            done    <= 1'b0;
          end else if (cmd_play) begin
            r_state <= S_FETCH;
            fl_addr <= START_ADDR;
            r_spd   <= w_spd_in;
            done    <= 1'b0;
            busy    <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          fl_req  <= 1'b0;
          write_s <= 1'b0;
          busy    <= 1'b0;
          paused  <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
